// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, the prefetch queue entry type and small PC/opcode
// helpers for the instruction fetch unit.
package ifu_pkg;

   localparam int ADDR_W     = 16;
   localparam int INSTR_W    = 16;
   localparam int OPCODE_MSB = 15;
   localparam int OPCODE_LSB = 12;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Next sequential word address; wraps 0xFFFF -> 0x0000.
   function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

   // Opcode field of an instruction word.
   function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous prefetch queue of fetch_entry_t. Flush empties the
// queue and takes priority over a same-cycle push; a same-cycle pop is simply
// absorbed by the flush.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  fetch_entry_t               push_data,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Pointer and occupancy control; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Entry storage has no reset; only slots covered by count are ever presented.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: decoupled fetch stage. Issues word-addressed requests to an
// in-order pipelined instruction memory, buffers returned instructions with
// their PCs in a prefetch queue, and flushes/restarts on datapath redirects.
// Credit rule: queued + in-flight fetches never exceed DEPTH.
// Optional macro IFU_BYPASS_EN: a response arriving at an empty queue is shown
// on the output in the same cycle and skips the queue if consumed at once.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = CW + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] rsp_pc;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     occupancy;
   logic [CW-1:0]     inflight_nx;
   logic [SW-1:0]     budget;
   logic              accept;
   logic              rsp_live;
   logic              rsp_keep;
   logic              bypass;
   logic              q_empty;
   logic              q_push;
   logic              q_pop;
   fetch_entry_t      q_head;
   fetch_entry_t      rsp_entry;

   // Request side: issue only while a queue slot is reserved for every fetch.
   assign budget         = {1'b0, occupancy} + {1'b0, inflight};
   assign imem_req_valid = !rst && (budget < SW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign accept         = imem_req_valid && imem_req_ready;

   // Response side: a response is live unless it belongs to a squashed fetch;
   // a redirect in the same cycle also squashes it.
   assign rsp_live  = imem_rsp_valid && (drop == '0);
   assign rsp_keep  = rsp_live && !redirect_valid;
   assign rsp_entry = '{pc: rsp_pc, instr: imem_rsp_data};
   assign q_empty   = (occupancy == '0);

`ifdef IFU_BYPASS_EN
   assign bypass = q_empty && rsp_live;
`else
   assign bypass = 1'b0;
`endif

   // Output side: queue head first; bypassed response only when the queue is empty.
   // Outputs are zeroed when nothing is valid so idle/reset values are clean.
   assign out_valid = !q_empty || bypass;
   assign out_pc    = !q_empty ? q_head.pc    : (bypass ? rsp_pc        : '0);
   assign out_instr = !q_empty ? q_head.instr : (bypass ? imem_rsp_data : '0);

   assign q_pop       = !q_empty && out_ready;
   assign q_push      = rsp_keep && !(bypass && out_ready);
   assign inflight_nx = inflight + CW'(accept) - CW'(imem_rsp_valid);

   ifu_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (q_push),
      .pop       (q_pop),
      .push_data (rsp_entry),
      .head      (q_head),
      .count     (occupancy)
   );

   // Fetch/response PC tracking plus outstanding-request and discard accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight_nx;
         if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
            drop     <= inflight_nx;
         end else begin
            if (accept)   fetch_pc <= pc_next(fetch_pc);
            if (rsp_keep) rsp_pc   <= pc_next(rsp_pc);
            if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
         end
      end
   end

`ifndef SYNTHESIS
   a_rsp_needs_inflight : assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (inflight != '0));
   a_credit_bound       : assert property (@(posedge clk) disable iff (rst)
      budget <= SW'(DEPTH));
   a_drop_bound         : assert property (@(posedge clk) disable iff (rst)
      drop <= inflight);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with an in-order,
// fixed-latency memory model. Build with IFU_BYPASS_EN defined to cover the
// bypass path; expectations adapt through the same macro.
module tb_instr_fetch_unit;
   import ifu_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [15:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [15:0] imem_rsp_data;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [15:0] out_pc;

   instr_fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   always #5 clk = ~clk;

   // Memory request in flight, tagged with the control-flow epoch it was fetched in.
   typedef struct {
      int unsigned due;
      logic [15:0] addr;
      int unsigned epoch;
   } mreq_t;

   // Redirect scenario: memory latency, accepts before redirect, target, and
   // the first four out_pc values required after the redirect.
   typedef struct {
      int unsigned      lat;
      int               n_req;
      logic [15:0]      rpc;
      logic             toggle;
      logic [3:0][15:0] exp_pc;
   } rvec_t;

   mreq_t        mq[$];
   fetch_entry_t sb[$];
   logic [15:0]  hs_log[$];

   int unsigned cyc;
   int unsigned epoch;
   int unsigned lat;
   int          n_chk;
   int          n_pass;
   int          n_acc;
   int          n_hs;
   logic [15:0] exp_fetch;
   logic        rst_g;
   logic        out_ready_g;
   logic        req_ready_g;
   logic        redir_g;
   logic        toggle_g;
   logic [15:0] redir_pc_g;

   function automatic logic [15:0] instr_of(input logic [15:0] a);
      return {a[3:0], a[15:4]} ^ 16'hC3A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   // One clock cycle: drive inputs at negedge, sample 1 time unit later.
   task automatic step();
      mreq_t        m;
      fetch_entry_t e;
      @(negedge clk);
      cyc++;
      rst            = rst_g;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'h0000;
      if (rst_g) begin
         mq.delete();
         sb.delete();
         epoch++;
         exp_fetch = RESET_PC;
      end else if (mq.size() != 0 && mq[0].due <= cyc) begin
         m = mq.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(m.addr);
         if (m.epoch == epoch) sb.push_back('{pc: m.addr, instr: instr_of(m.addr)});
      end
      if (toggle_g) begin
         out_ready      = ((cyc % 2) == 0);
         imem_req_ready = ((cyc % 3) != 0);
      end else begin
         out_ready      = out_ready_g;
         imem_req_ready = req_ready_g;
      end
      redirect_valid = redir_g;
      redirect_pc    = redir_pc_g;
      #1;
      if (rst_g) return;
      if (imem_req_valid && imem_req_ready) begin
         check("req_addr", 32'(imem_req_addr), 32'(exp_fetch));
         mq.push_back('{due: cyc + lat, addr: exp_fetch, epoch: epoch});
         exp_fetch = exp_fetch + 16'd1;
         n_acc++;
      end
      if (out_valid && out_ready) begin
         n_hs++;
         hs_log.push_back(out_pc);
         n_chk++;
         if (sb.size() == 0) begin
            $display("FAIL out_unexpected actual_pc=%0h required=no_output", out_pc);
         end else begin
            n_pass++;
            e = sb.pop_front();
            check("out_pc", 32'(out_pc), 32'(e.pc));
            check("out_instr", 32'(out_instr), 32'(e.instr));
         end
      end
      if (redirect_valid) begin
         sb.delete();
         epoch++;
         exp_fetch = redirect_pc;
      end
   endtask

   task automatic reset_dut(input int cycles);
      rst_g = 1'b1;
      repeat (cycles) step();
      rst_g = 1'b0;
   endtask

   task automatic check_log(input string name, input logic [3:0][15:0] exp);
      check({name, "_count"}, 32'(hs_log.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         if (k < hs_log.size())
            check($sformatf("%s_pc%0d", name, k), 32'(hs_log[k]), 32'(exp[k]));
   endtask

   initial begin
      rvec_t rv[5];
      int    pre;

      rv[0] = '{lat: 1, n_req: 3, rpc: 16'h0040, toggle: 1'b0,
                exp_pc: {16'h0043, 16'h0042, 16'h0041, 16'h0040}};
      rv[1] = '{lat: 3, n_req: 5, rpc: 16'h0040, toggle: 1'b0,
                exp_pc: {16'h0043, 16'h0042, 16'h0041, 16'h0040}};
      rv[2] = '{lat: 2, n_req: 2, rpc: 16'hFFFE, toggle: 1'b0,
                exp_pc: {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}};
      rv[3] = '{lat: 3, n_req: 4, rpc: 16'h1230, toggle: 1'b1,
                exp_pc: {16'h1233, 16'h1232, 16'h1231, 16'h1230}};
      rv[4] = '{lat: 1, n_req: 6, rpc: 16'h7FFF, toggle: 1'b0,
                exp_pc: {16'h8002, 16'h8001, 16'h8000, 16'h7FFF}};

      n_chk = 0; n_pass = 0; n_acc = 0; n_hs = 0;
      cyc = 0; epoch = 0; lat = 1;
      exp_fetch = RESET_PC;
      rst = 1'b1; rst_g = 1'b1;
      imem_req_ready = 1'b1; req_ready_g = 1'b1;
      out_ready = 1'b1; out_ready_g = 1'b1;
      imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0000;
      redirect_valid = 1'b0; redirect_pc = 16'h0000;
      redir_g = 1'b0; redir_pc_g = 16'h0000; toggle_g = 1'b0;

      // Reset values
      step();
      step();
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", 32'(out_instr), 32'd0);
      check("rst_out_pc", 32'(out_pc), 32'd0);
      rst_g = 1'b0;

      // Streaming, latency 1, always ready
      n_acc = 0;
      step();
      check("stream_req_valid", 32'(imem_req_valid), 32'd1);
      check("stream_first_addr", 32'(imem_req_addr), 32'(RESET_PC));
      step();
`ifdef IFU_BYPASS_EN
      check("stream_bypass_valid", 32'(out_valid), 32'd1);
      check("stream_bypass_pc", 32'(out_pc), 32'(RESET_PC));
`else
      check("stream_no_early_valid", 32'(out_valid), 32'd0);
`endif
      step();
      check("stream_valid_t2", 32'(out_valid), 32'd1);
`ifdef IFU_BYPASS_EN
      check("stream_pc_t2", 32'(out_pc), 32'h1);
`else
      check("stream_pc_t2", 32'(out_pc), 32'h0);
`endif
      pre = n_hs;
      repeat (10) step();
      check("stream_rate", 32'(n_hs - pre), 32'd10);

      // Backpressure: credit limit stops requests at DEPTH
      out_ready_g = 1'b0;
      lat = 1;
      reset_dut(2);
      n_acc = 0;
      repeat (12) step();
      check("bp_accepts", 32'(n_acc), 32'(DEPTH));
      check("bp_req_valid_low", 32'(imem_req_valid), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_head_pc", 32'(out_pc), 32'h0);
      hs_log.delete();
      out_ready_g = 1'b1;
      for (int c = 0; c < 12 && hs_log.size() < 4; c++) step();
      check_log("bp_drain", {16'h0003, 16'h0002, 16'h0001, 16'h0000});
      for (int c = 0; c < 4 && n_acc == DEPTH; c++) step();
      check("bp_resume", 32'(n_acc > DEPTH), 32'd1);

      // Redirect scenarios from the table
      for (int i = 0; i < 5; i++) begin
         lat = rv[i].lat;
         toggle_g = rv[i].toggle;
         out_ready_g = 1'b1;
         req_ready_g = 1'b1;
         reset_dut(2);
         n_acc = 0;
         for (int c = 0; c < 60 && n_acc < rv[i].n_req; c++) step();
         check($sformatf("row%0d_reqs", i), 32'(n_acc), 32'(rv[i].n_req));
         redir_g = 1'b1;
         redir_pc_g = rv[i].rpc;
         step();
         redir_g = 1'b0;
         hs_log.delete();
         step();
         check($sformatf("row%0d_valid_after_redirect", i), 32'(out_valid), 32'd0);
         for (int c = 0; c < 80 && hs_log.size() < 4; c++) step();
         check_log($sformatf("row%0d", i), rv[i].exp_pc);
      end
      toggle_g = 1'b0;

      // Redirect coinciding with an out handshake and a memory response
      lat = 1;
      out_ready_g = 1'b1;
      reset_dut(2);
      repeat (6) step();
      pre = n_hs;
      redir_g = 1'b1;
      redir_pc_g = 16'h0100;
      step();
      redir_g = 1'b0;
      check("sim_out_valid", 32'(out_valid), 32'd1);
      check("sim_rsp_valid", 32'(imem_rsp_valid), 32'd1);
      check("sim_hs_once", 32'(n_hs - pre), 32'd1);
      hs_log.delete();
      step();
      check("sim_valid_next", 32'(out_valid), 32'd0);
      for (int c = 0; c < 20 && hs_log.size() < 1; c++) step();
      check("sim_first_pc_count", 32'(hs_log.size()), 32'd1);
      if (hs_log.size() != 0) check("sim_first_pc", 32'(hs_log[0]), 32'h0100);

      // Reset in the middle of operation, then restart
      lat = 3;
      out_ready_g = 1'b0;
      reset_dut(2);
      n_acc = 0;
      for (int c = 0; c < 20 && n_acc < 3; c++) step();
      repeat (2) step();
      check("mid_queue_busy", 32'(out_valid), 32'd1);
      rst_g = 1'b1;
      step();
      step();
      check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_pc", 32'(out_pc), 32'd0);
      check("mid_rst_out_instr", 32'(out_instr), 32'd0);
      rst_g = 1'b0;
      lat = 1;
      out_ready_g = 1'b1;
      hs_log.delete();
      step();
      check("mid_restart_valid", 32'(imem_req_valid), 32'd1);
      check("mid_restart_addr", 32'(imem_req_addr), 32'(RESET_PC));
      step();
`ifdef IFU_BYPASS_EN
      check("mid_bypass_valid", 32'(out_valid), 32'd1);
      check("mid_bypass_pc", 32'(out_pc), 32'(RESET_PC));
`else
      check("mid_no_early_valid", 32'(out_valid), 32'd0);
`endif
      for (int c = 0; c < 10 && hs_log.size() < 4; c++) step();
      check_log("mid_restart", {16'h0003, 16'h0002, 16'h0001, 16'h0000});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
